// File: rtl/regfile_ctrl_pkg.sv
// Shared types and constants for the basic_cpu register-file access controller.
package regfile_ctrl_pkg;

  localparam int DATA_W       = 16;
  localparam int REG_CNT      = 8;
  localparam int IDX_W        = 3;
  localparam int RF_REGNUM_W  = 8;
  localparam int INIT_CNT_W   = 4;
  localparam int WB_BURST_MAX = 4;
  localparam int BURST_W      = 3;

  localparam logic [IDX_W-1:0]  SP_REG   = 3'd6;
  localparam logic [DATA_W-1:0] SP_RESET = 16'h0800;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    WR,
    RDS,
    RDD,
    CAP,
    DONE
  } state_e;

endpackage

// File: rtl/regfile_grant.sv
// IDLE-cycle grant decision between writeback and operand fetch, with a
// saturating burst counter that caps consecutive writes while a read waits.
module regfile_grant
  import regfile_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic wb_req,
  input  logic op_req,
  output logic grant_wr,
  output logic grant_rd
);

  logic [BURST_W-1:0] burst_q, burst_d;

  always_comb begin
    grant_wr = idle && wb_req && (!op_req || (burst_q < BURST_W'(WB_BURST_MAX)));
    grant_rd = idle && op_req && !grant_wr;

    burst_d = burst_q;
    if (!op_req || grant_rd) begin
      burst_d = '0;
    end else if (grant_wr && (burst_q != BURST_W'(WB_BURST_MAX))) begin
      burst_d = burst_q + BURST_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_q <= '0;
    end else begin
      burst_q <= burst_d;
    end
  end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Single-port register-file sequencer: init sweep, writeback and two-read
// operand fetch, with forwarding of a pending write into the operand latches.
//
// state | meaning
// INIT  | post-reset sweep, writes R0..R7 (SP_REG gets SP_RESET)
// IDLE  | no access; grant decision taken here
// WR    | writeback to wb_regnum, wb_ack pulses
// RDS   | read op_src presented
// RDD   | read op_dst presented, src data latched
// CAP   | dst data latched
// DONE  | op_ack pulses, operand values valid
module regfile_access_ctrl
  import regfile_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_req,
  input  logic [IDX_W-1:0]       wb_regnum,
  input  logic [DATA_W-1:0]      wb_data,
  output logic                   wb_ack,
  input  logic                   op_req,
  input  logic [IDX_W-1:0]       op_src,
  input  logic [IDX_W-1:0]       op_dst,
  output logic                   op_ack,
  output logic [DATA_W-1:0]      op_srcval,
  output logic [DATA_W-1:0]      op_dstval,
  output logic [RF_REGNUM_W-1:0] rf_regnum,
  output logic                   rf_rw,
  output logic [DATA_W-1:0]      rf_datain,
  input  logic [DATA_W-1:0]      rf_dataout,
  output logic                   busy
);

  localparam int PAD_W = RF_REGNUM_W - IDX_W;

  state_e                 state_q, state_d;
  logic [INIT_CNT_W-1:0]  init_cnt_q, init_cnt_d;
  logic                   wb_ack_q, wb_ack_d;
  logic                   op_ack_q, op_ack_d;
  logic [DATA_W-1:0]      op_srcval_q, op_srcval_d;
  logic [DATA_W-1:0]      op_dstval_q, op_dstval_d;
  logic [DATA_W-1:0]      src_lat_q, src_lat_d;
  logic [RF_REGNUM_W-1:0] rf_regnum_q, rf_regnum_d;
  logic                   rf_rw_q, rf_rw_d;
  logic [DATA_W-1:0]      rf_datain_q, rf_datain_d;
  logic                   busy_q, busy_d;

  logic                   grant_wr, grant_rd;
  logic [DATA_W-1:0]      fwd_src, fwd_dst;

  regfile_grant u_grant (
    .clk      (clk),
    .rst      (rst),
    .idle     (state_q == IDLE),
    .wb_req   (wb_req),
    .op_req   (op_req),
    .grant_wr (grant_wr),
    .grant_rd (grant_rd)
  );

  // A write still waiting for its slot is older than the read being captured.
  assign fwd_src = (wb_req && (wb_regnum == op_src)) ? wb_data : rf_dataout;
  assign fwd_dst = (wb_req && (wb_regnum == op_dst)) ? wb_data : rf_dataout;

  // Outputs are registered for the state being entered, so each state's
  // outputs are visible for exactly the cycle spent in it.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    wb_ack_d    = 1'b0;
    op_ack_d    = 1'b0;
    op_srcval_d = op_srcval_q;
    op_dstval_d = op_dstval_q;
    src_lat_d   = src_lat_q;
    rf_regnum_d = rf_regnum_q;
    rf_rw_d     = 1'b0;
    rf_datain_d = rf_datain_q;
    busy_d      = 1'b1;

    case (state_q)
      INIT: begin
        if (init_cnt_q == INIT_CNT_W'(REG_CNT)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          rf_rw_d     = 1'b1;
          rf_regnum_d = {{PAD_W{1'b0}}, init_cnt_q[IDX_W-1:0]};
          rf_datain_d = (init_cnt_q[IDX_W-1:0] == SP_REG) ? SP_RESET : '0;
          init_cnt_d  = init_cnt_q + INIT_CNT_W'(1);
        end
      end
      IDLE: begin
        if (grant_wr) begin
          state_d     = WR;
          rf_rw_d     = 1'b1;
          rf_regnum_d = {{PAD_W{1'b0}}, wb_regnum};
          rf_datain_d = wb_data;
          wb_ack_d    = 1'b1;
        end else if (grant_rd) begin
          state_d     = RDS;
          rf_regnum_d = {{PAD_W{1'b0}}, op_src};
        end else begin
          busy_d = 1'b0;
        end
      end
      WR: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      RDS: begin
        state_d     = RDD;
        rf_regnum_d = {{PAD_W{1'b0}}, op_dst};
      end
      RDD: begin
        state_d   = CAP;
        src_lat_d = fwd_src;
      end
      CAP: begin
        state_d     = DONE;
        op_srcval_d = src_lat_q;
        op_dstval_d = fwd_dst;
        op_ack_d    = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      wb_ack_q    <= 1'b0;
      op_ack_q    <= 1'b0;
      op_srcval_q <= '0;
      op_dstval_q <= '0;
      src_lat_q   <= '0;
      rf_regnum_q <= '0;
      rf_rw_q     <= 1'b0;
      rf_datain_q <= '0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      wb_ack_q    <= wb_ack_d;
      op_ack_q    <= op_ack_d;
      op_srcval_q <= op_srcval_d;
      op_dstval_q <= op_dstval_d;
      src_lat_q   <= src_lat_d;
      rf_regnum_q <= rf_regnum_d;
      rf_rw_q     <= rf_rw_d;
      rf_datain_q <= rf_datain_d;
      busy_q      <= busy_d;
    end
  end

  assign wb_ack    = wb_ack_q;
  assign op_ack    = op_ack_q;
  assign op_srcval = op_srcval_q;
  assign op_dstval = op_dstval_q;
  assign rf_regnum = rf_regnum_q;
  assign rf_rw     = rf_rw_q;
  assign rf_datain = rf_datain_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: behavioural regfile, transaction-level register model.
module tb_regfile_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_req = 1'b0;
  logic [2:0]  wb_regnum = '0;
  logic [15:0] wb_data = '0;
  logic        wb_ack;
  logic        op_req = 1'b0;
  logic [2:0]  op_src = '0;
  logic [2:0]  op_dst = '0;
  logic        op_ack;
  logic [15:0] op_srcval, op_dstval;
  logic [7:0]  rf_regnum;
  logic        rf_rw;
  logic [15:0] rf_datain;
  logic [15:0] rf_dataout = '0;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [15:0] rf_mem   [8];
  logic [15:0] exp_regs [8];

  regfile_access_ctrl dut (
    .clk(clk), .rst(rst),
    .wb_req(wb_req), .wb_regnum(wb_regnum), .wb_data(wb_data), .wb_ack(wb_ack),
    .op_req(op_req), .op_src(op_src), .op_dst(op_dst), .op_ack(op_ack),
    .op_srcval(op_srcval), .op_dstval(op_dstval),
    .rf_regnum(rf_regnum), .rf_rw(rf_rw), .rf_datain(rf_datain), .rf_dataout(rf_dataout),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port register file: read data appears the cycle after the address.
  always @(posedge clk) begin
    if (rf_rw === 1'b1) rf_mem[rf_regnum[2:0]] <= rf_datain;
    else                rf_dataout <= rf_mem[rf_regnum[2:0]];
  end

  initial begin
    for (int i = 0; i < 8; i++) rf_mem[i] = 16'hDEAD;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  task automatic model_init();
    for (int i = 0; i < 8; i++) exp_regs[i] = (i == 6) ? 16'h0800 : 16'h0000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_init();
  endtask

  task automatic run_op(input logic [2:0] s, input logic [2:0] d,
                        output int lat, output logic [15:0] sv, output logic [15:0] dv);
    int start;
    @(negedge clk);
    op_src = s; op_dst = d; op_req = 1'b1; start = cyc;
    lat = -1; sv = 'x; dv = 'x;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (op_ack) begin
        lat = cyc - start; sv = op_srcval; dv = op_dstval;
        break;
      end
    end
    op_req = 1'b0;
  endtask

  task automatic run_wb(input logic [2:0] r, input logic [15:0] d, output int lat);
    int start;
    @(negedge clk);
    wb_regnum = r; wb_data = d; wb_req = 1'b1; start = cyc; lat = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wb_ack) begin
        lat = cyc - start;
        break;
      end
    end
    wb_req = 1'b0;
  endtask

  task automatic run_both(input logic [2:0] r, input logic [15:0] d,
                          input logic [2:0] s, input logic [2:0] dd,
                          output int wb_lat, output int op_lat,
                          output logic [15:0] sv, output logic [15:0] dv);
    int start;
    @(negedge clk);
    wb_regnum = r; wb_data = d; wb_req = 1'b1;
    op_src = s; op_dst = dd; op_req = 1'b1;
    start = cyc; wb_lat = -1; op_lat = -1; sv = 'x; dv = 'x;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wb_ack) begin
        wb_lat = cyc - start; wb_req = 1'b0;
      end
      if (op_ack) begin
        op_lat = cyc - start; sv = op_srcval; dv = op_dstval; op_req = 1'b0;
        break;
      end
    end
    wb_req = 1'b0; op_req = 1'b0;
  endtask

  task automatic test_reset();
    int lat; logic [15:0] sv, dv, exp_din;
    do_reset();
    n_checks++;
    if ({wb_ack, op_ack, op_srcval, op_dstval, rf_rw, rf_regnum, rf_datain, busy} !==
        {1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 8'h0, 16'h0, 1'b1})
      $display("FAIL reset_outputs: got ack=%b/%b sv=%h dv=%h rw=%b rn=%h din=%h busy=%b expected 0/0 0 0 0 00 0 busy=1",
               wb_ack, op_ack, op_srcval, op_dstval, rf_rw, rf_regnum, rf_datain, busy);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_din = (i == 6) ? 16'h0800 : 16'h0000;
      n_checks++;
      if ({busy, rf_rw, rf_regnum, rf_datain, wb_ack, op_ack} !== {1'b1, 1'b1, 8'(i), exp_din, 1'b0, 1'b0})
        $display("FAIL init_write_%0d: got busy=%b rw=%b rn=%h din=%h expected busy=1 rw=1 rn=%h din=%h",
                 i, busy, rf_rw, rf_regnum, rf_datain, 8'(i), exp_din);
      else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if ({busy, rf_rw} !== 2'b00)
      $display("FAIL init_to_idle: got busy=%b rw=%b expected busy=0 rw=0", busy, rf_rw);
    else n_pass++;
    run_op(3'd6, 3'd0, lat, sv, dv);
    n_checks++;
    if ({sv, dv} !== {exp_regs[6], exp_regs[0]})
      $display("FAIL init_values: got src=%h dst=%h expected src=%h dst=%h", sv, dv, exp_regs[6], exp_regs[0]);
    else n_pass++;
  endtask

  task automatic test_wb_then_op();
    int lat; logic [15:0] sv, dv;
    run_wb(3'd3, 16'hBEEF, lat);
    exp_regs[3] = 16'hBEEF;
    n_checks++;
    if (lat !== 1) $display("FAIL wb_latency: got %0d expected 1", lat);
    else n_pass++;
    run_op(3'd3, 3'd3, lat, sv, dv);
    n_checks++;
    if (lat !== 4) $display("FAIL op_latency: got %0d expected 4", lat);
    else n_pass++;
    n_checks++;
    if ({sv, dv} !== {exp_regs[3], exp_regs[3]})
      $display("FAIL same_reg_op: got src=%h dst=%h expected %h/%h", sv, dv, exp_regs[3], exp_regs[3]);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    int wl, ol; logic [15:0] sv, dv;
    run_both(3'd2, 16'h1234, 3'd2, 3'd5, wl, ol, sv, dv);
    exp_regs[2] = 16'h1234;
    n_checks++;
    if (wl !== 1 || ol !== 6)
      $display("FAIL simul_order: got wb_lat=%0d op_lat=%0d expected 1/6", wl, ol);
    else n_pass++;
    n_checks++;
    if ({sv, dv} !== {exp_regs[2], exp_regs[5]})
      $display("FAIL simul_values: got src=%h dst=%h expected %h/%h", sv, dv, exp_regs[2], exp_regs[5]);
    else n_pass++;
  endtask

  task automatic test_forward();
    int lat; logic got; logic [15:0] sv, dv;
    @(negedge clk);
    op_src = 3'd1; op_dst = 3'd0; op_req = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, rf_rw, rf_regnum} !== {1'b1, 1'b0, 8'd1})
      $display("FAIL fwd_rds_state: got busy=%b rw=%b rn=%h expected 1 0 01", busy, rf_rw, rf_regnum);
    else n_pass++;
    @(negedge clk);
    wb_regnum = 3'd1; wb_data = 16'hAAAA; wb_req = 1'b1;
    got = 1'b0; sv = 'x; dv = 'x;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (op_ack) begin got = 1'b1; sv = op_srcval; dv = op_dstval; break; end
    end
    op_req = 1'b0;
    n_checks++;
    if ({got, sv, dv} !== {1'b1, 16'hAAAA, exp_regs[0]})
      $display("FAIL fwd_values: got ack=%b src=%h dst=%h expected 1 AAAA %h", got, sv, dv, exp_regs[0]);
    else n_pass++;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wb_ack) begin got = 1'b1; break; end
    end
    wb_req = 1'b0;
    exp_regs[1] = 16'hAAAA;
    run_op(3'd1, 3'd1, lat, sv, dv);
    n_checks++;
    if ({got, sv, dv} !== {1'b1, exp_regs[1], exp_regs[1]})
      $display("FAIL fwd_write_kept: got wb_ack=%b src=%h dst=%h expected 1 %h/%h", got, sv, dv, exp_regs[1], exp_regs[1]);
    else n_pass++;
  endtask

  task automatic test_burst();
    int nwb; logic got; logic [15:0] sv, dv;
    @(negedge clk);
    wb_regnum = 3'd4; wb_data = 16'($urandom); wb_req = 1'b1;
    op_src = 3'd0; op_dst = 3'd6; op_req = 1'b1;
    nwb = 0; got = 1'b0; sv = 'x; dv = 'x;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wb_ack) begin
        nwb++; exp_regs[4] = wb_data; wb_data = 16'($urandom);
      end
      if (op_ack) begin
        got = 1'b1; sv = op_srcval; dv = op_dstval; break;
      end
    end
    op_req = 1'b0; wb_req = 1'b0;
    n_checks++;
    if ({got, nwb} !== {1'b1, 32'd4})
      $display("FAIL burst_count: got ack=%b wb_acks=%0d expected 1 and 4", got, nwb);
    else n_pass++;
    n_checks++;
    if ({sv, dv} !== {exp_regs[0], exp_regs[6]})
      $display("FAIL burst_values: got src=%h dst=%h expected %h/%h", sv, dv, exp_regs[0], exp_regs[6]);
    else n_pass++;
    run_op(3'd4, 3'd4, nwb, sv, dv);
    n_checks++;
    if (sv !== exp_regs[4])
      $display("FAIL burst_last_write: got %h expected %h", sv, exp_regs[4]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    int nw; logic got; logic [15:0] sv, dv;
    @(negedge clk);
    op_src = 3'd6; op_dst = 3'd2; op_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_init();
    n_checks++;
    if ({op_ack, busy, rf_rw, op_srcval, op_dstval} !== {1'b0, 1'b1, 1'b0, 16'h0, 16'h0})
      $display("FAIL midreset_outputs: got ack=%b busy=%b rw=%b sv=%h dv=%h expected 0 1 0 0 0",
               op_ack, busy, rf_rw, op_srcval, op_dstval);
    else n_pass++;
    nw = 0; got = 1'b0; sv = 'x; dv = 'x;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rf_rw) nw++;
      if (op_ack) begin got = 1'b1; sv = op_srcval; dv = op_dstval; break; end
    end
    op_req = 1'b0;
    n_checks++;
    if ({got, nw} !== {1'b1, 32'd8})
      $display("FAIL midreset_replay: got ack=%b writes_before_ack=%0d expected 1 and 8", got, nw);
    else n_pass++;
    n_checks++;
    if ({sv, dv} !== {exp_regs[6], exp_regs[2]})
      $display("FAIL midreset_values: got src=%h dst=%h expected %h/%h", sv, dv, exp_regs[6], exp_regs[2]);
    else n_pass++;
  endtask

  task automatic test_random();
    int kind, wl, ol; logic [2:0] r, s, d; logic [15:0] data, sv, dv;
    for (int it = 0; it < 24; it++) begin
      kind = int'($urandom_range(0, 2));
      r = 3'($urandom); s = 3'($urandom); d = 3'($urandom); data = 16'($urandom);
      if (kind == 0) begin
        run_wb(r, data, wl);
        exp_regs[r] = data;
        n_checks++;
        if (wl !== 1) $display("FAIL rand_wb_%0d: got lat %0d expected 1", it, wl);
        else n_pass++;
      end else if (kind == 1) begin
        run_op(s, d, ol, sv, dv);
        n_checks++;
        if ({ol, sv, dv} !== {32'd4, exp_regs[s], exp_regs[d]})
          $display("FAIL rand_op_%0d: got lat=%0d src=%h dst=%h expected 4 %h %h", it, ol, sv, dv, exp_regs[s], exp_regs[d]);
        else n_pass++;
      end else begin
        run_both(r, data, s, d, wl, ol, sv, dv);
        exp_regs[r] = data;
        n_checks++;
        if ({wl, ol, sv, dv} !== {32'd1, 32'd6, exp_regs[s], exp_regs[d]})
          $display("FAIL rand_both_%0d: got wl=%0d ol=%0d src=%h dst=%h expected 1 6 %h %h",
                   it, wl, ol, sv, dv, exp_regs[s], exp_regs[d]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    model_init();
    @(negedge clk);
    test_reset();
    test_wb_then_op();
    test_simultaneous();
    test_forward();
    test_burst();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
